// File: rtl/test_status_mon_pkg.sv
// Shared HISOC definitions for the end-of-test monitor: register indices, the end magic value
// and the monitor state encoding.
package test_status_mon_pkg;

  localparam int DEF_CPU_WIDTH = 32;

  localparam logic [4:0] REG_GP  = 5'd3;
  localparam logic [4:0] REG_S10 = 5'd26;
  localparam logic [4:0] REG_S11 = 5'd27;

  localparam int END_MAGIC = 1;

  typedef enum logic [1:0] {
    MON_IDLE   = 2'd0,
    MON_RUN    = 2'd1,
    MON_SETTLE = 2'd2,
    MON_DONE   = 2'd3
  } mon_state_e;

endpackage

// File: rtl/test_status_mon_cnt.sv
// Loadable down-counter with a zero flag; stops at zero.
module test_status_mon_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/test_status_mon.sv
// End-of-test monitor: snoops register-file writes for the x26/x27 pass/fail convention,
// captures the x3 test number and runs a watchdog over hung programs.
module test_status_mon #(
  parameter int CPU_WIDTH      = test_status_mon_pkg::DEF_CPU_WIDTH,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 rf_wen,
  input  logic [4:0]           rf_waddr,
  input  logic [CPU_WIDTH-1:0] rf_wdata,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [CPU_WIDTH-1:0] fail_testnum,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  import test_status_mon_pkg::*;

  localparam int                   SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0]     SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WD_LOAD     = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CPU_WIDTH-1:0] MAGIC       = CPU_WIDTH'(END_MAGIC);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  mon_state_e           state, state_nxt;
  logic                 trigger, settle_zero, wd_zero;
  logic                 active, run_entry, settle_load, settle_dec, wd_dec, finish, to_idle;
  logic                 settle_pass;
  logic [CPU_WIDTH-1:0] x3_sh, x27_sh, x3_nxt, x27_nxt;

  // The trigger is the x26 write itself, so only x3 and x27 need shadows.
  assign trigger = rf_wen && (rf_waddr == REG_S10) && (rf_wdata == MAGIC);
  assign x3_nxt  = (rf_wen && rf_waddr == REG_GP)  ? rf_wdata : x3_sh;
  assign x27_nxt = (rf_wen && rf_waddr == REG_S11) ? rf_wdata : x27_sh;
  assign settle_pass = (x27_nxt == MAGIC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MON_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MON_IDLE:   if (enable) state_nxt = MON_RUN;
      MON_RUN: begin
        if (!enable)      state_nxt = MON_IDLE;
        else if (trigger) state_nxt = MON_SETTLE;
        else if (wd_zero) state_nxt = MON_DONE;
      end
      MON_SETTLE: begin
        if (!enable)          state_nxt = MON_IDLE;
        else if (settle_zero) state_nxt = MON_DONE;
      end
      MON_DONE:   if (!enable || clear) state_nxt = MON_IDLE;
      default:    state_nxt = MON_IDLE;
    endcase
  end

  always_comb begin
    done        = (state == MON_DONE);
    active      = enable && (state == MON_RUN || state == MON_SETTLE);
    run_entry   = enable && (state == MON_IDLE);
    settle_load = enable && (state == MON_RUN) && trigger;
    settle_dec  = (state == MON_SETTLE);
    wd_dec      = (state == MON_RUN);
    finish      = active && (state_nxt == MON_DONE);
    to_idle     = (state != MON_IDLE) && (state_nxt == MON_IDLE);
  end

  test_status_mon_cnt #(.WIDTH(SET_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load),
    .dec      (settle_dec),
    .load_val (SETTLE_LOAD),
    .zero     (settle_zero)
  );

  // Watchdog tracks cycle_cnt == TIMEOUT_CYCLES-1 without a wide comparator on the saturating count.
  test_status_mon_cnt #(.WIDTH(CNT_WIDTH)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (run_entry),
    .dec      (wd_dec),
    .load_val (WD_LOAD),
    .zero     (wd_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x3_sh        <= '0;
      x27_sh       <= '0;
      cycle_cnt    <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else if (run_entry || to_idle) begin
      x3_sh        <= '0;
      x27_sh       <= '0;
      cycle_cnt    <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else begin
      if (active) begin
        x3_sh     <= x3_nxt;
        x27_sh    <= x27_nxt;
        cycle_cnt <= sat_inc(cycle_cnt);
      end
      if (finish) begin
        pass         <= (state == MON_SETTLE) && settle_pass;
        fail         <= !((state == MON_SETTLE) && settle_pass);
        timeout      <= (state == MON_RUN);
        fail_testnum <= x3_nxt;
      end
    end
  end

endmodule
